// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator sequencer.
package calc_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_WAIT = 2'd2,
        S_RES  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_EQ  = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;

    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// BCD operand register: clear, parallel load, or shift in a digit from the
// right. A digit is dropped once the most significant nibble is non-zero.
module bcd_entry_reg
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             n_reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             append_i,
    input  logic [3:0]       digit_i,
    output logic [BCD_W-1:0] value_o,
    output logic [BCD_W-1:0] value_nx_o
);

    logic [BCD_W-1:0] value_q, value_d;

    // Next value: clear beats load beats append.
    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (load_i) begin
            value_d = load_val_i;
        end else if (append_i && (value_q[BCD_W-1 -: 4] == 4'd0)) begin
            value_d = {value_q[BCD_W-5:0], digit_i};
        end
    end

    // Operand storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (!n_reset) value_q <= '0;
        else          value_q <= value_d;
    end

    assign value_o    = value_q;
    assign value_nx_o = value_d;

endmodule

// File: rtl/keypad_calc_sequencer.sv
// Keypad-to-adder-to-display sequencer: operand entry, adder handshake
// with timeout, and result display.
//
// state  | meaning
// S_A    | entering operand A, display shows A
// S_B    | entering operand B, display shows B
// S_WAIT | add_req high, waiting for add_ack or timeout, display shows B
// S_RES  | showing latched result (or 0 after timeout)
module keypad_calc_sequencer
    import calc_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [11:0] op_a,
    output logic [11:0] op_b,
    output logic        add_req,
    input  logic        add_ack,
    input  logic [12:0] add_sum,
    output logic [11:0] cdu,
    output logic [3:0]  led
);

    // Abort happens on the edge that would bring the count to ACK_TIMEOUT,
    // so add_req stays high for exactly ACK_TIMEOUT cycles.
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic [11:0] cdu_q, cdu_d;

    logic        key_digit, key_add, key_eq, key_clr;
    logic        a_clear, a_load, a_append;
    logic [11:0] a_load_val;
    logic        b_clear, b_append;
    logic [11:0] a_q, a_nx, b_q, b_nx;

    bcd_entry_reg u_op_a (
        .clk        (clk),
        .n_reset    (n_reset),
        .clear_i    (a_clear),
        .load_i     (a_load),
        .load_val_i (a_load_val),
        .append_i   (a_append),
        .digit_i    (key_code),
        .value_o    (a_q),
        .value_nx_o (a_nx)
    );

    bcd_entry_reg u_op_b (
        .clk        (clk),
        .n_reset    (n_reset),
        .clear_i    (b_clear),
        .load_i     (1'b0),
        .load_val_i (12'h000),
        .append_i   (b_append),
        .digit_i    (key_code),
        .value_o    (b_q),
        .value_nx_o (b_nx)
    );

    // Key decode, next-state logic and operand register controls.
    always_comb begin
        key_digit  = key_valid && is_digit(key_code);
        key_add    = key_valid && (key_code == KEY_ADD);
        key_eq     = key_valid && (key_code == KEY_EQ);
        key_clr    = key_valid && (key_code == KEY_CLR);

        state_d    = state_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        a_clear    = 1'b0;
        a_load     = 1'b0;
        a_load_val = result_q;
        a_append   = 1'b0;
        b_clear    = 1'b0;
        b_append   = 1'b0;

        if (key_clr) begin
            state_d  = S_A;
            cnt_d    = 8'd0;
            result_d = 12'h000;
            ovf_d    = 1'b0;
            err_d    = 1'b0;
            a_clear  = 1'b1;
            b_clear  = 1'b1;
        end else begin
            case (state_q)
                S_A: begin
                    if (key_digit) begin
                        a_append = 1'b1;
                    end else if (key_add) begin
                        b_clear = 1'b1;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (key_digit) begin
                        b_append = 1'b1;
                    end else if (key_eq) begin
                        cnt_d   = 8'd0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (add_ack) begin
                        result_d = add_sum[11:0];
                        ovf_d    = add_sum[12];
                        state_d  = S_RES;
                    end else if (cnt_q == TMO_LAST) begin
                        result_d = 12'h000;
                        err_d    = 1'b1;
                        state_d  = S_RES;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_RES: begin
                    if (key_digit) begin
                        a_load     = 1'b1;
                        a_load_val = {8'h00, key_code};
                        ovf_d      = 1'b0;
                        err_d      = 1'b0;
                        state_d    = S_A;
                    end else if (key_add) begin
                        a_load     = 1'b1;
                        a_load_val = result_q;
                        b_clear    = 1'b1;
                        ovf_d      = 1'b0;
                        err_d      = 1'b0;
                        state_d    = S_B;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    // Display source follows the state being entered next cycle.
    always_comb begin
        case (state_d)
            S_A:     cdu_d = a_nx;
            S_B:     cdu_d = b_nx;
            S_WAIT:  cdu_d = b_nx;
            default: cdu_d = result_d;
        endcase
    end

    // State, timeout counter, result/flags and display register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q  <= S_A;
            cnt_q    <= 8'd0;
            result_q <= 12'h000;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            cdu_q    <= 12'h000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            cdu_q    <= cdu_d;
        end
    end

    assign op_a    = a_q;
    assign op_b    = b_q;
    assign cdu     = cdu_q;
    assign add_req = (state_q == S_WAIT);
    assign led     = {ovf_q | err_q, state_q == S_WAIT, 2'(state_q)};

endmodule

// File: tb/tb_keypad_calc_sequencer.sv
// Bench for keypad_calc_sequencer: directed vector table, hand sequences for
// the handshake corners, then random traffic against a decimal-level model.
module tb_keypad_calc_sequencer;

    localparam int TMO = 10;
    localparam int MA = 0, MB = 1, MW = 2, MR = 3;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        add_ack = 1'b0;
    logic [12:0] add_sum = 13'h0;
    logic [11:0] op_a, op_b, cdu;
    logic        add_req;
    logic [3:0]  led;

    int vectors = 0;
    int miscompares = 0;

    // decimal-level model
    int          m_mode, m_a, m_b, m_wait;
    logic [11:0] m_res;
    logic        m_flag;

    keypad_calc_sequencer #(.ACK_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .add_req   (add_req),
        .add_ack   (add_ack),
        .add_sum   (add_sum),
        .cdu       (cdu),
        .led       (led)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] int2bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int bcd2int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [12:0] sum13(input int v);
        return {v >= 1000, int2bcd(v % 1000)};
    endfunction

    function automatic int app(input int v, input int d);
        return (v < 100) ? v * 10 + d : v;
    endfunction

    task automatic model_step();
        if (!n_reset || (key_valid && key_code == 4'hC)) begin
            m_mode = MA; m_a = 0; m_b = 0; m_res = 12'h0; m_flag = 1'b0; m_wait = 0;
        end else begin
            case (m_mode)
                MA: if (key_valid && key_code <= 4'd9) m_a = app(m_a, int'(key_code));
                    else if (key_valid && key_code == 4'hA) begin m_mode = MB; m_b = 0; end
                MB: if (key_valid && key_code <= 4'd9) m_b = app(m_b, int'(key_code));
                    else if (key_valid && key_code == 4'hB) begin m_mode = MW; m_wait = 0; end
                MW: if (add_ack) begin
                        m_res = add_sum[11:0]; m_flag = add_sum[12]; m_mode = MR;
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin m_res = 12'h0; m_flag = 1'b1; m_mode = MR; end
                    end
                default: if (key_valid && key_code <= 4'd9) begin
                        m_a = int'(key_code); m_flag = 1'b0; m_mode = MA;
                    end else if (key_valid && key_code == 4'hA) begin
                        m_a = bcd2int(m_res); m_b = 0; m_flag = 1'b0; m_mode = MB;
                    end
            endcase
        end
    endtask

    function automatic logic [40:0] model_out();
        logic [11:0] c;
        case (m_mode)
            MA:      c = int2bcd(m_a);
            MR:      c = m_res;
            default: c = int2bcd(m_b);
        endcase
        return {c, int2bcd(m_a), int2bcd(m_b), m_mode == MW,
                m_flag, m_mode == MW, 2'(m_mode)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1; key_code = k;
        tick();
        key_valid = 1'b0;
    endtask

    typedef struct {
        logic        nrst;
        logic        kv;
        logic [3:0]  kc;
        logic        ack;
        logic [12:0] sum;
        logic [11:0] e_cdu;
        logic [11:0] e_opa;
        logic [11:0] e_opb;
        logic [3:0]  e_led;
    } vec_t;

    vec_t tbl[26];

    initial begin
        int cnt;
        logic [3:0] r;

        //           nrst kv  kc    ack sum       cdu     opa     opb     led
        tbl[0]  = '{1'b0, 0, 4'h0, 0, 13'h0000, 12'h000, 12'h000, 12'h000, 4'b0000};
        tbl[1]  = '{1'b1, 1, 4'h1, 0, 13'h0000, 12'h001, 12'h001, 12'h000, 4'b0000};
        tbl[2]  = '{1'b1, 1, 4'h2, 0, 13'h0000, 12'h012, 12'h012, 12'h000, 4'b0000};
        tbl[3]  = '{1'b1, 1, 4'h3, 0, 13'h0000, 12'h123, 12'h123, 12'h000, 4'b0000};
        tbl[4]  = '{1'b1, 1, 4'h4, 0, 13'h0000, 12'h123, 12'h123, 12'h000, 4'b0000};
        tbl[5]  = '{1'b1, 1, 4'hE, 0, 13'h0000, 12'h123, 12'h123, 12'h000, 4'b0000};
        tbl[6]  = '{1'b1, 1, 4'hB, 0, 13'h0000, 12'h123, 12'h123, 12'h000, 4'b0000};
        tbl[7]  = '{1'b1, 1, 4'hC, 0, 13'h0000, 12'h000, 12'h000, 12'h000, 4'b0000};
        tbl[8]  = '{1'b1, 1, 4'h4, 0, 13'h0000, 12'h004, 12'h004, 12'h000, 4'b0000};
        tbl[9]  = '{1'b1, 1, 4'h5, 0, 13'h0000, 12'h045, 12'h045, 12'h000, 4'b0000};
        tbl[10] = '{1'b1, 1, 4'hA, 0, 13'h0000, 12'h000, 12'h045, 12'h000, 4'b0001};
        tbl[11] = '{1'b1, 1, 4'hF, 0, 13'h0000, 12'h000, 12'h045, 12'h000, 4'b0001};
        tbl[12] = '{1'b1, 1, 4'h6, 0, 13'h0000, 12'h006, 12'h045, 12'h006, 4'b0001};
        tbl[13] = '{1'b1, 1, 4'h7, 0, 13'h0000, 12'h067, 12'h045, 12'h067, 4'b0001};
        tbl[14] = '{1'b1, 1, 4'hA, 0, 13'h0000, 12'h067, 12'h045, 12'h067, 4'b0001};
        tbl[15] = '{1'b1, 1, 4'hB, 0, 13'h0000, 12'h067, 12'h045, 12'h067, 4'b0110};
        tbl[16] = '{1'b1, 0, 4'h0, 0, 13'h0000, 12'h067, 12'h045, 12'h067, 4'b0110};
        tbl[17] = '{1'b1, 1, 4'h9, 0, 13'h0000, 12'h067, 12'h045, 12'h067, 4'b0110};
        tbl[18] = '{1'b1, 0, 4'h0, 1, 13'h0112, 12'h112, 12'h045, 12'h067, 4'b0011};
        tbl[19] = '{1'b1, 0, 4'h0, 1, 13'h1999, 12'h112, 12'h045, 12'h067, 4'b0011};
        tbl[20] = '{1'b1, 1, 4'h5, 0, 13'h0000, 12'h005, 12'h005, 12'h067, 4'b0000};
        tbl[21] = '{1'b1, 1, 4'hA, 0, 13'h0000, 12'h000, 12'h005, 12'h000, 4'b0001};
        tbl[22] = '{1'b1, 1, 4'h1, 0, 13'h0000, 12'h001, 12'h005, 12'h001, 4'b0001};
        tbl[23] = '{1'b1, 1, 4'hB, 0, 13'h0000, 12'h001, 12'h005, 12'h001, 4'b0110};
        tbl[24] = '{1'b1, 1, 4'hC, 1, 13'h0006, 12'h000, 12'h000, 12'h000, 4'b0000};
        tbl[25] = '{1'b1, 0, 4'h0, 0, 13'h0000, 12'h000, 12'h000, 12'h000, 4'b0000};

        for (int i = 0; i < 26; i++) begin
            n_reset = tbl[i].nrst; key_valid = tbl[i].kv; key_code = tbl[i].kc;
            add_ack = tbl[i].ack;  add_sum = tbl[i].sum;
            tick();
            chk($sformatf("tbl%0d_cdu", i), cdu, tbl[i].e_cdu);
            chk($sformatf("tbl%0d_opa", i), op_a, tbl[i].e_opa);
            chk($sformatf("tbl%0d_opb", i), op_b, tbl[i].e_opb);
            chk($sformatf("tbl%0d_led", i), led, tbl[i].e_led);
            chk($sformatf("tbl%0d_req", i), add_req, tbl[i].e_led[2]);
        end
        n_reset = 1'b1; key_valid = 1'b0; add_ack = 1'b0; add_sum = 13'h0;

        // 999 + 999 with thousands carry, then chained sum
        key(4'hC);
        key(4'h9); key(4'h9); key(4'h9); key(4'hA);
        key(4'h9); key(4'h9); key(4'h9); key(4'hB);
        tick();
        add_ack = 1'b1; add_sum = 13'h1998;
        tick();
        add_ack = 1'b0;
        chk("ovf_cdu", cdu, 12'h998);
        chk("ovf_led", led, 4'b1011);
        key(4'hA);
        chk("chain_opa", op_a, 12'h998);
        chk("chain_led", led, 4'b0001);
        key(4'h1);
        chk("chain_cdu", cdu, 12'h001);
        chk("chain_led3", led[3], 1'b0);

        // timeout with no ack, then a late ack
        key(4'hC);
        key(4'h2); key(4'hA); key(4'h3); key(4'hB);
        cnt = 0;
        while (add_req && cnt < 50) begin
            cnt++;
            tick();
        end
        chk("tmo_req_cycles", cnt, TMO);
        chk("tmo_cdu", cdu, 12'h000);
        chk("tmo_led", led, 4'b1011);
        add_ack = 1'b1; add_sum = 13'h0555;
        tick();
        add_ack = 1'b0;
        chk("late_ack_cdu", cdu, 12'h000);
        chk("late_ack_led", led, 4'b1011);

        // reset in the middle of the handshake
        key(4'hC);
        key(4'h3); key(4'h2); key(4'h1);
        chk("rst_opa_pre", op_a, 12'h321);
        key(4'hA); key(4'hB);
        tick(); tick();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        chk("rst_all", {cdu, op_a, op_b, add_req, led}, 41'h0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            n_reset   = ($urandom_range(0, 199) != 0);
            key_valid = ($urandom_range(0, 2) == 0);
            r = 4'($urandom_range(0, 19));
            if (r < 4'd10)      key_code = r;
            else if (r < 4'd13) key_code = 4'hA;
            else if (r < 4'd16) key_code = 4'hB;
            else                key_code = 4'($urandom_range(12, 15));
            add_ack = ($urandom_range(0, 5) == 0);
            add_sum = sum13(m_a + m_b);
            tick();
            chk($sformatf("rand%0d", i), {cdu, op_a, op_b, add_req, led}, model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_calc_sequencer.md
# keypad_calc_sequencer

Controller that sequences the keypad-to-adder-to-display path of the calculator. It consumes debounced key events from the keypad scanner and assembles two 3-digit BCD operands. It then runs a request/acknowledge transaction with the BCD adder and drives the 12-bit `cdu` word consumed by the display mux. It sits between `lecture` (upstream) and `sume`/`mux` (downstream) and owns all entry/result state.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 255: maximum cycles spent waiting for `add_ack` before aborting with error (1..255).

Ports:
- `clk`  in  1  system clock.
- `n_reset`  in  1  synchronous, active-low reset.
- `key_valid`  in  1  one-cycle pulse: `key_code` holds a new debounced key.
- `key_code`  in  4  0x0–0x9 digit, 0xA '+', 0xB '=', 0xC clear, 0xD–0xF ignored.
- `op_a`  out  12  BCD operand A to adder (hundreds/tens/units nibbles).
- `op_b`  out  12  BCD operand B to adder.
- `add_req`  out  1  addition request, level.
- `add_ack`  in  1  one-cycle pulse: `add_sum` valid.
- `add_sum`  in  13  BCD result: bit 12 = thousands carry, [11:0] three BCD digits.
- `cdu`  out  12  display value, [11:8] hundreds, [7:4] tens, [3:0] units.
- `led`  out  4  debug: [1:0] state code, [2] `add_req`, [3] overflow or error.

## Operation
- States (2-bit code): `S_A`=0 (enter A), `S_B`=1 (enter B), `S_WAIT`=2 (adder handshake), `S_RES`=3 (show result).
- Digit append: `op <= {op[7:0], digit}` only if `op[11:8]==0`; otherwise the digit is dropped (3 digits max, no wrap).
- `S_A`:
  - digit → append to `op_a`.
  - '+' → `S_B`, `op_b<=0`.
  - '=' ignored.
  - `cdu=op_a`.
- `S_B`:
  - digit → append to `op_b`.
  - '=' → `S_WAIT`.
  - '+' ignored.
  - `cdu=op_b`.
- `S_WAIT`:
  - `add_req=1`; `op_a`/`op_b` held stable.
  - Timeout counter increments each cycle.
  - On `add_ack`: latch `result<=add_sum[11:0]`, `ovf<=add_sum[12]`, go to `S_RES`.
  - If counter reaches `ACK_TIMEOUT` first: `result<=0`, `err<=1`, go to `S_RES`.
  - Digit, '+' and '=' ignored.
  - `cdu=op_b`.
- `S_RES`:
  - `cdu=result`.
  - digit → `S_A` with `op_a<=digit`, `ovf/err` cleared.
  - '+' → `op_a<=result`, `op_b<=0`, go to `S_B` (chained sum), `ovf/err` cleared.
  - '=' ignored.
- Clear (0xC), in any state: next cycle `S_A`, `op_a=op_b=result=0`, `ovf=err=0`, `add_req=0`. During `S_WAIT` this aborts the transaction.
- `add_ack` outside `S_WAIT` is ignored. A late ack after an abort or timeout has no effect.
- Keys 0xD–0xF are ignored in all states.

## Timing
- Reset values (cycle after `n_reset` sampled low):
  - `S_A`, `op_a=op_b=0`, `cdu=0`.
  - `add_req=0`, `led=4'b0000`.
  - Timeout counter 0, `result=0`, `ovf=err=0`.
- Reset has priority over all inputs, including mid-handshake; `add_req` drops in the reset cycle.
- Each accepted key takes effect on the edge where `key_valid=1`. Updated `cdu`/state are visible the next cycle.
- '=' accepted at edge N → `add_req=1` from cycle N+1.
- `add_ack` sampled at edge M → `add_req=0` and `cdu=result` from M+1.
- `key_valid` and `add_ack` in the same cycle in `S_WAIT`:
  - clear wins (transaction aborted);
  - any other key is ignored and the ack is taken.
- Timeout counter: 8 bits, reset to 0 on entry to `S_WAIT`. Abort happens on the cycle the count equals `ACK_TIMEOUT` with no ack.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `calc_pkg`:
  - `state_t` enum (2-bit codes above);
  - key constants `KEY_ADD=4'hA`, `KEY_EQ=4'hB`, `KEY_CLR=4'hC`;
  - `BCD_DIGITS=3`.
- Sub-module `bcd_entry_reg`: 12-bit BCD register with `clear`, `load(12)` and `append(digit)` controls and the full-guard rule. Instantiated twice, for `op_a` and `op_b`.
- The FSM, timeout counter and result/flag registers live in the top of the block.

## Test plan
- Enter keys 1,2,3,4 → `cdu=12'h123`, 4th digit dropped, `led[1:0]=0`.
- Keys 4,5,+,6,7,= with `add_ack` 3 cycles after `add_req`, `add_sum=13'h0112`:
  - `op_a=12'h045`, `op_b=12'h067`;
  - `add_req` high exactly 3 cycles;
  - `cdu=12'h112`, `led[1:0]=3`.
- Keys 9,9,9,+,9,9,9,= with `add_sum=13'h1998` → `cdu=12'h998`, `led[3]=1`. Then '+', 1 → `op_a=12'h998`, `cdu=12'h001`, `led[3]=0`.
- '=' with no ack and `ACK_TIMEOUT=10` → `add_req` drops after 10 cycles, `cdu=0`, `led[3]=1`. A late `add_ack` then changes nothing.
- Clear pulsed in the same cycle as `add_ack` in `S_WAIT` → `S_A`, all zeros, `add_sum` discarded.
- `n_reset` low during `S_WAIT` with `op_a=12'h321` → next cycle all outputs at reset values. Keys 0xE/0xF in every state cause no change.
